// File: rtl/word_serializer_if.sv
// Handshake bundle for word_serializer: parallel word in, serial bit stream out.
// The slave modport is the serializer; the master modport is the surrounding logic.
interface word_serializer_if #(
    parameter int DEPTH = 8
);
    logic [DEPTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             out;
    logic             out_valid;
    logic             out_ready;
    logic             done;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out,
        output out_valid,
        input  out_ready,
        output done
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out,
        input  out_valid,
        output out_ready,
        input  done
    );
endinterface

// File: rtl/word_serializer.sv
// MSB-first parallel-to-serial converter with valid/ready on both sides.
// Defining WORD_SERIALIZER_PARITY_EN appends an even-parity bit after the data bits.
module word_serializer #(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    word_serializer_if.slave  bus
);
    localparam int              CNT_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

`ifdef WORD_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [DEPTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             out_q, out_d;
    logic             done_q, done_d;
    logic             xfer;
`ifdef WORD_SERIALIZER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // A bit moves only when it is actually on the wire and the consumer takes it.
    assign xfer = out_valid_q & bus.out_ready;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        done_d      = 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
        parity_d    = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d     = SHIFT;
                    shreg_d     = bus.in_data;
                    cnt_d       = '0;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    out_d       = bus.in_data[DEPTH-1];
`ifdef WORD_SERIALIZER_PARITY_EN
                    parity_d    = ^bus.in_data;
`endif
                end
            end
            SHIFT: begin
                if (xfer) begin
                    shreg_d = {shreg_q[DEPTH-2:0], 1'b0};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
`ifdef WORD_SERIALIZER_PARITY_EN
                        state_d     = PARITY;
                        out_d       = parity_q;
`else
                        state_d     = IDLE;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        out_d       = 1'b0;
                        done_d      = 1'b1;
`endif
                    end else begin
                        // Next bit on the wire is the one just below the current MSB.
                        out_d = shreg_q[DEPTH-2];
                    end
                end
            end
`ifdef WORD_SERIALIZER_PARITY_EN
            PARITY: begin
                if (xfer) begin
                    state_d     = IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                    out_d       = 1'b0;
                    done_d      = 1'b1;
                end
            end
`endif
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                out_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= 1'b0;
            done_q      <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            done_q      <= done_d;
`ifdef WORD_SERIALIZER_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer (DEPTH=8): table of words plus hand-written
// sequences for back-to-back words and reset mid-word.
module tb_word_serializer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    word_serializer_if #(.DEPTH(8)) bus ();

    word_serializer #(.DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] word;
        logic [7:0] exp_bits;  // bit 7 is the first bit expected on the wire
        logic       exp_par;
        int         stall_at;  // bit index held while out_ready is low, -1 for none
        int         stall_len;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %b want %b", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input logic [7:0] eb, input logic ep,
                             input int stall_at, input int stall_len);
        check("in_ready_idle", 0, bus.in_ready, 1'b1);
        bus.in_data   = w;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (b == stall_at) begin
                bus.out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check("stall_valid", b, bus.out_valid, 1'b1);
                    check("stall_out", b, bus.out, eb[7-b]);
                    step();
                end
                bus.out_ready = 1'b1;
            end
            check("valid", b, bus.out_valid, 1'b1);
            check("bit", b, bus.out, eb[7-b]);
            check("busy", b, bus.in_ready, 1'b0);
            check("done_early", b, bus.done, 1'b0);
            step();
        end
`ifdef WORD_SERIALIZER_PARITY_EN
        check("par_valid", 8, bus.out_valid, 1'b1);
        check("par_bit", 8, bus.out, ep);
        check("par_done_early", 8, bus.done, 1'b0);
        step();
`endif
        check("done", 0, bus.done, 1'b1);
        check("ready_back", 0, bus.in_ready, 1'b1);
        check("valid_low", 0, bus.out_valid, 1'b0);
        check("out_low", 0, bus.out, 1'b0);
        step();
        check("done_pulse", 0, bus.done, 1'b0);
        $display("word %h stall_at %0d len %0d parity %b checks %0d errors %0d",
                 w, stall_at, stall_len, ep, checks, errors);
    endtask

    task automatic check_reset_state(input int idx);
        check("rst_in_ready", idx, bus.in_ready, 1'b1);
        check("rst_out_valid", idx, bus.out_valid, 1'b0);
        check("rst_out", idx, bus.out, 1'b0);
        check("rst_done", idx, bus.done, 1'b0);
    endtask

    initial begin
        logic [7:0] second_bits;
        checks = 0;
        errors = 0;

        vecs[0] = '{word: 8'hA5, exp_bits: 8'b1010_0101, exp_par: 1'b0, stall_at: -1, stall_len: 0};
        vecs[1] = '{word: 8'hC3, exp_bits: 8'b1100_0011, exp_par: 1'b0, stall_at: 2,  stall_len: 3};
        vecs[2] = '{word: 8'h07, exp_bits: 8'b0000_0111, exp_par: 1'b1, stall_at: -1, stall_len: 0};
        vecs[3] = '{word: 8'h03, exp_bits: 8'b0000_0011, exp_par: 1'b0, stall_at: -1, stall_len: 0};
        vecs[4] = '{word: 8'h80, exp_bits: 8'b1000_0000, exp_par: 1'b1, stall_at: 7,  stall_len: 2};
        vecs[5] = '{word: 8'h00, exp_bits: 8'b0000_0000, exp_par: 1'b0, stall_at: 0,  stall_len: 1};

        reset         = 1'b1;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        check_reset_state(0);
        step();
        reset = 1'b0;
        check_reset_state(1);
        $display("reset released checks %0d errors %0d", checks, errors);

        for (int i = 0; i < 6; i++) begin
            send_word(vecs[i].word, vecs[i].exp_bits, vecs[i].exp_par,
                      vecs[i].stall_at, vecs[i].stall_len);
        end

        // Back-to-back: the second word waits on in_valid until the first completes.
        bus.in_data   = 8'hFF;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_data = 8'h01;
        for (int b = 0; b < 8; b++) begin
            check("b2b_first_bit", b, bus.out, 1'b1);
            check("b2b_first_valid", b, bus.out_valid, 1'b1);
            check("b2b_first_busy", b, bus.in_ready, 1'b0);
            step();
        end
`ifdef WORD_SERIALIZER_PARITY_EN
        check("b2b_first_par", 8, bus.out, 1'b0);
        step();
`endif
        check("b2b_done", 0, bus.done, 1'b1);
        check("b2b_ready", 0, bus.in_ready, 1'b1);
        step();
        bus.in_valid = 1'b0;
        second_bits  = 8'b0000_0001;
        for (int b = 0; b < 8; b++) begin
            check("b2b_second_bit", b, bus.out, second_bits[7-b]);
            check("b2b_second_valid", b, bus.out_valid, 1'b1);
            step();
        end
`ifdef WORD_SERIALIZER_PARITY_EN
        check("b2b_second_par", 8, bus.out, 1'b1);
        step();
`endif
        check("b2b_done2", 0, bus.done, 1'b1);
        step();
        check("b2b_done2_pulse", 0, bus.done, 1'b0);
        $display("word ff then 01 back-to-back checks %0d errors %0d", checks, errors);

        // Reset in the middle of 8'hF0 after three bits have gone out.
        bus.in_data  = 8'hF0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            check("abort_bit", b, bus.out, 1'b1);
            step();
        end
        reset = 1'b1;
        #1;
        check_reset_state(2);
        step();
        reset = 1'b0;
        check_reset_state(3);
        step();
        check_reset_state(4);
        $display("word f0 aborted by reset checks %0d errors %0d", checks, errors);
        send_word(8'h81, 8'b1000_0001, 1'b0, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
